// File: rtl/dcache_pkg.sv
// Shared types and AXI constants for the write-through data cache.
// Holds the FSM encoding and the byte-strobe to AXI transfer-size mapping.
package dcache_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MISS_AR,
    S_REFILL,
    S_RESP,
    S_WR_AW,
    S_WR_W,
    S_WR_B
  } state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_W     = 3'b010;

  // Single-beat writes advertise the narrowest size that covers a naturally
  // aligned strobe pattern; anything irregular falls back to a full word.
  function automatic logic [2:0] strb_to_size(input logic [3:0] strb);
    case (strb)
      4'b1111:                            return 3'b010;
      4'b0011, 4'b1100:                   return 3'b001;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: return 3'b000;
      default:                            return 3'b010;
    endcase
  endfunction

endpackage

// File: rtl/dcache_way_store.sv
// One cache way: tag array, valid vector and per-word data banks with byte enables.
// Reads return one cycle after the index is presented; writes land on the clock edge.
module dcache_way_store #(
  parameter int SETS       = 128,
  parameter int LINE_WORDS = 8,
  parameter int TAG_W      = 20,
  localparam int IDX_W     = $clog2(SETS),
  localparam int OFF_W     = $clog2(LINE_WORDS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_i,
  input  logic [IDX_W-1:0]        rd_idx_i,
  output logic [TAG_W-1:0]        rd_tag_o,
  output logic                    rd_valid_o,
  output logic [LINE_WORDS*32-1:0] rd_line_o,
  input  logic [IDX_W-1:0]        wr_idx_i,
  input  logic [OFF_W-1:0]        wr_off_i,
  input  logic [3:0]              wr_be_i,
  input  logic [31:0]             wr_data_i,
  input  logic                    word_we_i,
  input  logic                    tag_we_i,
  input  logic [TAG_W-1:0]        wr_tag_i
);

  logic [TAG_W-1:0]         tag_mem  [SETS];
  logic [31:0]              data_mem [LINE_WORDS][SETS];
  logic [SETS-1:0]          valid_q;
  logic [TAG_W-1:0]         rd_tag_q;
  logic                     rd_valid_q;
  logic [LINE_WORDS*32-1:0] rd_line_q;

  always_ff @(posedge clk) begin
    if (tag_we_i) tag_mem[wr_idx_i] <= wr_tag_i;
    if (word_we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be_i[b]) data_mem[wr_off_i][wr_idx_i][8*b +: 8] <= wr_data_i[8*b +: 8];
      end
    end
    rd_tag_q <= tag_mem[rd_idx_i];
    for (int w = 0; w < LINE_WORDS; w++) begin
      rd_line_q[32*w +: 32] <= data_mem[w][rd_idx_i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      if (flush_i) valid_q <= '0;
      else if (tag_we_i) valid_q[wr_idx_i] <= 1'b1;
      rd_valid_q <= valid_q[rd_idx_i];
    end
  end

  assign rd_tag_o   = rd_tag_q;
  assign rd_valid_o = rd_valid_q;
  assign rd_line_o  = rd_line_q;

endmodule

// File: rtl/dcache_wt_param.sv
// Parametrised write-through, no-write-allocate D-cache; read hit in 1 cycle, misses and all writes go to AXI.
// One request in flight; CPU holds requests while s_busy. DCACHE_PERF_CNT_EN adds hit/miss/uncached counters.
module dcache_wt_param
  import dcache_pkg::*;
#(
  parameter int WAYS       = 2,
  parameter int SETS       = 128,
  parameter int LINE_WORDS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_addr,
  input  logic        s_arvalid,
  input  logic [3:0]  s_awvalid,
  input  logic [31:0] s_wdata,
  input  logic        s_uncached,
  input  logic        flush,
  output logic [31:0] s_rdata,
  output logic        s_rvalid,
  output logic        s_wready,
  output logic        s_busy,
`ifdef DCACHE_PERF_CNT_EN
  output logic [31:0] perf_hit,
  output logic [31:0] perf_miss,
  output logic [31:0] perf_uncached,
`endif
  output logic [31:0] m_araddr,
  output logic [7:0]  m_arlen,
  output logic [2:0]  m_arsize,
  output logic [1:0]  m_arburst,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic        m_rlast,
  input  logic        m_rvalid,
  output logic        m_rready,
  output logic [31:0] m_awaddr,
  output logic [7:0]  m_awlen,
  output logic [2:0]  m_awsize,
  output logic [1:0]  m_awburst,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wlast,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic        m_bvalid,
  output logic        m_bready
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - OFF_W - IDX_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  state_e               state_q, state_d;
  logic [31:0]          addr_q, wdata_q, capt_q;
  logic [3:0]           strb_q;
  logic                 unc_q, wr_q;
  logic [WAY_W-1:0]     victim_q, victim_d, hit_way;
  logic [OFF_W-1:0]     beat_q;
  logic [WAY_W-1:0]     rr_q [SETS];
  logic                 hit, acc_rd, acc_wr;
  logic [31:0]          hit_word;

  logic [IDX_W-1:0]     idx_q, rd_idx;
  logic [OFF_W-1:0]     off_q;
  logic [TAG_W-1:0]     tag_q;

  logic [TAG_W-1:0]          way_tag   [WAYS];
  logic [LINE_WORDS*32-1:0]  way_line  [WAYS];
  logic [WAYS-1:0]           way_valid;
  logic [WAYS-1:0]           word_we, tag_we;
  logic [OFF_W-1:0]          wr_off;
  logic [3:0]                wr_be;
  logic [31:0]               wr_data;

  assign idx_q  = addr_q[2+OFF_W +: IDX_W];
  assign off_q  = addr_q[2 +: OFF_W];
  assign tag_q  = addr_q[31 -: TAG_W];
  // Arrays are read with the incoming address so tags are ready in LOOKUP.
  assign rd_idx = (state_q == S_IDLE) ? s_addr[2+OFF_W +: IDX_W] : idx_q;

  assign acc_rd = (state_q == S_IDLE) && !flush && s_arvalid;
  assign acc_wr = (state_q == S_IDLE) && !flush && !s_arvalid && (s_awvalid != 4'b0000);

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    dcache_way_store #(.SETS(SETS), .LINE_WORDS(LINE_WORDS), .TAG_W(TAG_W)) u_way (
      .clk       (clk),
      .rst       (rst),
      .flush_i   (acc_rd == 1'b0 && (state_q == S_IDLE) && flush),
      .rd_idx_i  (rd_idx),
      .rd_tag_o  (way_tag[g]),
      .rd_valid_o(way_valid[g]),
      .rd_line_o (way_line[g]),
      .wr_idx_i  (idx_q),
      .wr_off_i  (wr_off),
      .wr_be_i   (wr_be),
      .wr_data_i (wr_data),
      .word_we_i (word_we[g]),
      .tag_we_i  (tag_we[g]),
      .wr_tag_i  (tag_q)
    );
  end

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && way_valid[w] && (way_tag[w] == tag_q)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    hit_word = way_line[hit_way][{off_q, 5'd0} +: 32];
  end

  // Fill the lowest invalid way before disturbing any live line.
  always_comb begin
    logic found;
    found    = 1'b0;
    victim_d = rr_q[idx_q];
    for (int w = 0; w < WAYS; w++) begin
      if (!found && !way_valid[w]) begin
        found    = 1'b1;
        victim_d = WAY_W'(w);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    s_rvalid = 1'b0;
    s_wready = 1'b0;
    s_rdata  = '0;
    word_we  = '0;
    tag_we   = '0;
    wr_off   = off_q;
    wr_be    = strb_q;
    wr_data  = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (acc_rd)      state_d = s_uncached ? S_MISS_AR : S_LOOKUP;
        else if (acc_wr) state_d = s_uncached ? S_WR_AW : S_LOOKUP;
      end
      S_LOOKUP: begin
        if (wr_q) begin
          if (hit) word_we[hit_way] = 1'b1;
          state_d = S_WR_AW;
        end else if (hit) begin
          s_rvalid = 1'b1;
          s_rdata  = hit_word;
          state_d  = S_IDLE;
        end else begin
          state_d = S_MISS_AR;
        end
      end
      S_MISS_AR: if (m_arready) state_d = S_REFILL;
      S_REFILL: begin
        wr_off  = beat_q;
        wr_be   = 4'hF;
        wr_data = m_rdata;
        if (m_rvalid) begin
          if (!unc_q) begin
            word_we[victim_q] = 1'b1;
            tag_we[victim_q]  = m_rlast;
          end
          if (m_rlast) state_d = S_RESP;
        end
      end
      S_RESP: begin
        s_rvalid = 1'b1;
        s_rdata  = capt_q;
        state_d  = S_IDLE;
      end
      S_WR_AW: if (m_awready) state_d = S_WR_W;
      S_WR_W:  if (m_wready) state_d = S_WR_B;
      S_WR_B: begin
        if (m_bvalid) begin
          s_wready = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      strb_q   <= '0;
      unc_q    <= 1'b0;
      wr_q     <= 1'b0;
      victim_q <= '0;
      beat_q   <= '0;
      capt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (acc_rd || acc_wr) begin
        addr_q  <= s_addr;
        wdata_q <= s_wdata;
        strb_q  <= acc_wr ? s_awvalid : 4'b0000;
        unc_q   <= s_uncached;
        wr_q    <= acc_wr;
      end
      if (state_q == S_LOOKUP) victim_q <= victim_d;
      if (state_q == S_MISS_AR) begin
        beat_q <= '0;
      end else if (state_q == S_REFILL && m_rvalid) begin
        beat_q <= beat_q + 1'b1;
        if (unc_q || beat_q == off_q) capt_q <= m_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
    end else if (state_q == S_REFILL && m_rvalid && m_rlast && !unc_q) begin
      rr_q[idx_q] <= (rr_q[idx_q] == WAY_W'(WAYS-1)) ? '0 : rr_q[idx_q] + 1'b1;
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] perf_hit_q, perf_miss_q, perf_unc_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_hit_q  <= '0;
      perf_miss_q <= '0;
      perf_unc_q  <= '0;
    end else begin
      if (state_q == S_LOOKUP && !wr_q && hit) perf_hit_q <= perf_hit_q + 1'b1;
      if (state_q == S_RESP && !unc_q) perf_miss_q <= perf_miss_q + 1'b1;
      if (state_q == S_RESP && unc_q)  perf_unc_q  <= perf_unc_q + 1'b1;
    end
  end
  assign perf_hit      = perf_hit_q;
  assign perf_miss     = perf_miss_q;
  assign perf_uncached = perf_unc_q;
`endif

  assign s_busy    = (state_q != S_IDLE);
  assign m_arvalid = (state_q == S_MISS_AR);
  assign m_araddr  = unc_q ? addr_q : {addr_q[31:OFF_W+2], {(OFF_W+2){1'b0}}};
  assign m_arlen   = unc_q ? 8'd0 : 8'(LINE_WORDS - 1);
  assign m_arsize  = SIZE_W;
  assign m_arburst = BURST_INCR;
  assign m_rready  = 1'b1;
  assign m_awvalid = (state_q == S_WR_AW);
  assign m_awaddr  = addr_q;
  assign m_awlen   = 8'd0;
  assign m_awsize  = strb_to_size(strb_q);
  assign m_awburst = BURST_INCR;
  assign m_wvalid  = (state_q == S_WR_W);
  assign m_wdata   = wdata_q;
  assign m_wstrb   = strb_q;
  assign m_wlast   = (state_q == S_WR_W);
  assign m_bready  = 1'b1;

endmodule

// File: tb/tb_dcache_wt_param.sv
// Randomised bench for dcache_wt_param: AXI slave with backing memory plus an abstract
// set/way occupancy model that predicts hits, misses and round-robin evictions.
module tb_dcache_wt_param;

  localparam int WAYS = 2, SETS = 128, LINE_WORDS = 8;
  localparam int LB = LINE_WORDS * 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] s_addr, s_wdata, s_rdata;
  logic        s_arvalid, s_uncached, flush, s_rvalid, s_wready, s_busy;
  logic [3:0]  s_awvalid;
  logic [31:0] m_araddr, m_rdata, m_awaddr, m_wdata;
  logic [7:0]  m_arlen, m_awlen;
  logic [2:0]  m_arsize, m_awsize;
  logic [1:0]  m_arburst, m_awburst;
  logic        m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
  logic        m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [3:0]  m_wstrb;
`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] perf_hit, perf_miss, perf_uncached;
`endif

  dcache_wt_param #(.WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LINE_WORDS)) dut (
    .clk(clk), .rst(rst), .s_addr(s_addr), .s_arvalid(s_arvalid), .s_awvalid(s_awvalid),
    .s_wdata(s_wdata), .s_uncached(s_uncached), .flush(flush), .s_rdata(s_rdata),
    .s_rvalid(s_rvalid), .s_wready(s_wready), .s_busy(s_busy),
`ifdef DCACHE_PERF_CNT_EN
    .perf_hit(perf_hit), .perf_miss(perf_miss), .perf_uncached(perf_uncached),
`endif
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_rdata(m_rdata), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
    .m_awsize(m_awsize), .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
    .m_wready(m_wready), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  int n_checks = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    n_checks++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp_v);
    end
  endtask

  // Backing memory; untouched words return an address-derived pattern.
  logic [31:0] mem [int unsigned];
  function automatic logic [31:0] mrd(input logic [31:0] a);
    int unsigned k = a >> 2;
    if (mem.exists(k)) return mem[k];
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  int d_ar = 0, d_aw = 0, d_w = 0, d_b = 0;
  int ar_cnt = 0, aw_cnt = 0, b_cnt = 0;
  int stable_err = 0, conc_err = 0, early_err = 0;
  logic [31:0] ar_addr_l, aw_addr_l, w_data_l;
  logic [7:0]  ar_len_l, aw_len_l;
  logic [2:0]  ar_size_l, aw_size_l;
  logic [1:0]  ar_burst_l, aw_burst_l;
  logic [3:0]  w_strb_l;
  logic        w_last_l;

  // AR/R responder
  initial begin
    logic [31:0] a;
    logic [7:0]  n;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0; m_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst && m_arvalid) begin
        a = m_araddr; n = m_arlen;
        ar_cnt++; ar_addr_l = a; ar_len_l = n; ar_size_l = m_arsize; ar_burst_l = m_arburst;
        for (int i = 0; i < d_ar; i++) begin
          @(posedge clk); #1;
          if (!m_arvalid || m_araddr !== a) stable_err++;
        end
        m_arready = 1'b1;
        @(posedge clk); #1;
        m_arready = 1'b0;
        for (int i = 0; i <= int'(n); i++) begin
          m_rvalid = 1'b1;
          m_rdata  = mrd(a + 32'(4 * i));
          m_rlast  = (i == int'(n));
          @(posedge clk); #1;
        end
        m_rvalid = 1'b0; m_rlast = 1'b0;
      end
    end
  end

  // AW/W/B responder; applies the write to the backing memory
  initial begin
    logic [31:0] a, wd, cur;
    logic [3:0]  st;
    int t;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst && m_awvalid) begin
        a = m_awaddr;
        aw_cnt++; aw_addr_l = a; aw_len_l = m_awlen; aw_size_l = m_awsize; aw_burst_l = m_awburst;
        if (m_wvalid) conc_err++;
        for (int i = 0; i < d_aw; i++) begin
          @(posedge clk); #1;
          if (!m_awvalid || m_awaddr !== a) stable_err++;
          if (m_wvalid) conc_err++;
        end
        m_awready = 1'b1;
        @(posedge clk); #1;
        m_awready = 1'b0;
        t = 0;
        while (!m_wvalid && t < 100) begin @(posedge clk); #1; t++; end
        chk("w_valid_seen", 32'(m_wvalid), 32'd1);
        wd = m_wdata; st = m_wstrb;
        w_data_l = wd; w_strb_l = st; w_last_l = m_wlast;
        for (int i = 0; i < d_w; i++) begin
          @(posedge clk); #1;
          if (!m_wvalid || m_wdata !== wd) stable_err++;
        end
        m_wready = 1'b1;
        @(posedge clk); #1;
        m_wready = 1'b0;
        cur = mrd(a);
        for (int b = 0; b < 4; b++) if (st[b]) cur[8*b +: 8] = wd[8*b +: 8];
        mem[a >> 2] = cur;
        for (int i = 0; i < d_b; i++) begin
          @(posedge clk); #1;
          if (s_wready) early_err++;
        end
        m_bvalid = 1'b1; b_cnt++;
        @(posedge clk); #1;
        m_bvalid = 1'b0;
      end
    end
  end

  // Abstract occupancy model: which tags live in which set, and the eviction pointer.
  bit mval [SETS][WAYS];
  int mtag [SETS][WAYS];
  int mrr  [SETS];

  task automatic model_read(input logic [31:0] a, output bit hit);
    int s, tg, v;
    s  = int'((a / LB) % SETS);
    tg = int'(a / (LB * SETS));
    hit = 1'b0;
    for (int w = 0; w < WAYS; w++) if (mval[s][w] && mtag[s][w] == tg) hit = 1'b1;
    if (!hit) begin
      v = -1;
      for (int w = 0; w < WAYS; w++) if (v < 0 && !mval[s][w]) v = w;
      if (v < 0) v = mrr[s];
      mval[s][v] = 1'b1;
      mtag[s][v] = tg;
      mrr[s] = (mrr[s] + 1) % WAYS;
    end
  endtask

  function automatic logic [2:0] exp_size(input logic [3:0] s);
    if (s == 4'b1111) return 3'd2;
    if (s == 4'b0011 || s == 4'b1100) return 3'd1;
    if ($countones(s) == 1) return 3'd0;
    return 3'd2;
  endfunction

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (s_busy && t < 300) begin tick(); t++; end
    if (s_busy) chk("idle_timeout", 32'(s_busy), 32'd0);
  endtask

  task automatic cpu_read(input logic [31:0] a, input bit unc, input bit also_wr);
    bit hit;
    int lat, ar0, aw0;
    logic [31:0] ev;
    wait_idle();
    hit = 1'b0;
    if (!unc) model_read(a, hit);
    ev = mrd(a);
    ar0 = ar_cnt; aw0 = aw_cnt;
    s_addr = a; s_uncached = unc; s_arvalid = 1'b1;
    if (also_wr) begin s_awvalid = 4'hF; s_wdata = 32'hDEAD_0000; end
    tick();
    s_arvalid = 1'b0; s_awvalid = 4'h0;
    lat = 1;
    while (!s_rvalid && lat < 300) begin tick(); lat++; end
    chk("rd_done", 32'(s_rvalid), 32'd1);
    chk("rd_data", s_rdata, ev);
    if (hit) begin
      chk("hit_latency", 32'(lat), 32'd1);
      chk("hit_no_ar", 32'(ar_cnt - ar0), 32'd0);
    end else begin
      chk("miss_ar_cnt", 32'(ar_cnt - ar0), 32'd1);
      chk("ar_addr", ar_addr_l, unc ? a : (a & ~32'(LB - 1)));
      chk("ar_len", 32'(ar_len_l), unc ? 32'd0 : 32'(LINE_WORDS - 1));
      chk("ar_size", 32'(ar_size_l), 32'd2);
      chk("ar_burst", 32'(ar_burst_l), 32'd1);
    end
    tick();
    chk("rvalid_pulse", 32'(s_rvalid), 32'd0);
    if (also_wr) chk("rd_over_wr_no_aw", 32'(aw_cnt - aw0), 32'd0);
  endtask

  task automatic cpu_write(input logic [31:0] a, input logic [3:0] st, input logic [31:0] d, input bit unc);
    int t, aw0, b0;
    wait_idle();
    aw0 = aw_cnt; b0 = b_cnt;
    s_addr = a; s_awvalid = st; s_wdata = d; s_uncached = unc;
    tick();
    s_awvalid = 4'h0;
    t = 1;
    while (!s_wready && t < 300) begin tick(); t++; end
    chk("wr_done", 32'(s_wready), 32'd1);
    chk("wr_with_b", 32'(m_bvalid), 32'd1);
    chk("b_cnt", 32'(b_cnt - b0), 32'd1);
    chk("aw_cnt", 32'(aw_cnt - aw0), 32'd1);
    chk("aw_addr", aw_addr_l, a);
    chk("aw_len", 32'(aw_len_l), 32'd0);
    chk("aw_size", 32'(aw_size_l), 32'(exp_size(st)));
    chk("aw_burst", 32'(aw_burst_l), 32'd1);
    chk("w_strb", 32'(w_strb_l), 32'(st));
    chk("w_data", w_data_l, d);
    chk("w_last", 32'(w_last_l), 32'd1);
    tick();
    chk("wready_pulse", 32'(s_wready), 32'd0);
  endtask

  // Flush is asserted alongside a read to show that flush wins and nothing is accepted.
  task automatic cpu_flush();
    wait_idle();
    flush = 1'b1; s_arvalid = 1'b1; s_addr = 32'h1000_0024; s_uncached = 1'b0;
    tick();
    flush = 1'b0; s_arvalid = 1'b0;
    chk("flush_blocks_req", 32'(s_busy), 32'd0);
    for (int s = 0; s < SETS; s++) for (int w = 0; w < WAYS; w++) mval[s][w] = 1'b0;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog expired got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, d;
    logic [3:0]  st;
    int op;
    rst = 1'b1; s_addr = '0; s_arvalid = 1'b0; s_awvalid = 4'h0; s_wdata = '0;
    s_uncached = 1'b0; flush = 1'b0;
    for (int s = 0; s < SETS; s++) begin
      mrr[s] = 0;
      for (int w = 0; w < WAYS; w++) begin mval[s][w] = 1'b0; mtag[s][w] = 0; end
    end
    for (int i = 0; i < 8; i++) mem[(32'h1000_0020 >> 2) + i] = 32'h0000_00A0 + 32'(i);

    repeat (3) tick();
    chk("rst_busy", 32'(s_busy), 32'd0);
    chk("rst_rvalid", 32'(s_rvalid), 32'd0);
    chk("rst_wready", 32'(s_wready), 32'd0);
    chk("rst_rdata", s_rdata, 32'd0);
    chk("rst_arvalid", 32'(m_arvalid), 32'd0);
    chk("rst_awvalid", 32'(m_awvalid), 32'd0);
    chk("rst_wvalid", 32'(m_wvalid), 32'd0);
    rst = 1'b0;
    tick();

    // Cold miss then hit on the same line
    cpu_read(32'h1000_0024, 1'b0, 1'b0);
    cpu_read(32'h1000_0028, 1'b0, 1'b0);
    // Halfword write hit, then the merged word reads back on a hit
    cpu_write(32'h1000_0024, 4'b0011, 32'h0000_BEEF, 1'b0);
    cpu_read(32'h1000_0024, 1'b0, 1'b0);
    chk("merged_word", mrd(32'h1000_0024), 32'h0000_BEEF);
    // Three tags in one set: round-robin eviction
    cpu_read(32'h2000_0040, 1'b0, 1'b0);
    cpu_read(32'h2000_1040, 1'b0, 1'b0);
    cpu_read(32'h2000_2040, 1'b0, 1'b0);
    cpu_read(32'h2000_1040, 1'b0, 1'b0);
    cpu_read(32'h2000_0040, 1'b0, 1'b0);
    // Uncached reads always go to the bus and leave the arrays alone
    cpu_read(32'h1FAF_0000, 1'b1, 1'b0);
    cpu_read(32'h1FAF_0000, 1'b1, 1'b0);
    cpu_read(32'h1FAF_0000, 1'b0, 1'b0);
    // Flush, then refill; simultaneous read+write accepts only the read
    cpu_flush();
    cpu_read(32'h1000_0024, 1'b0, 1'b0);
    cpu_read(32'h1000_0028, 1'b0, 1'b1);
    // Slow slave on every channel
    d_ar = 5; d_aw = 5; d_w = 5; d_b = 5;
    cpu_read(32'h2000_3044, 1'b0, 1'b0);
    cpu_write(32'h2000_3048, 4'b0100, 32'h00C3_0000, 1'b0);
    cpu_read(32'h2000_3048, 1'b0, 1'b0);

    for (int it = 0; it < 80; it++) begin
      d_ar = $urandom_range(0, 2); d_aw = $urandom_range(0, 2);
      d_w  = $urandom_range(0, 2); d_b  = $urandom_range(0, 2);
      op = $urandom_range(0, 99);
      a = 32'h3000_0000 + 32'($urandom_range(0, 4)) * 32'h1000
        + 32'($urandom_range(0, 1)) * 32'(LB) + 32'($urandom_range(0, 7)) * 32'd4;
      d = $urandom;
      st = 4'($urandom_range(1, 15));
      if (op < 55)      cpu_read(a, 1'b0, 1'b0);
      else if (op < 80) cpu_write(a, st, d, 1'b0);
      else if (op < 88) cpu_read(32'h1FAF_0000 + 32'($urandom_range(0, 63)) * 32'd4, 1'b1, 1'b0);
      else if (op < 95) cpu_write(32'h1FAE_0000 + 32'($urandom_range(0, 63)) * 32'd4, st, d, 1'b1);
      else              cpu_flush();
    end

    wait_idle();
    repeat (4) tick();
    chk("valid_stable", 32'(stable_err), 32'd0);
    chk("aw_w_sequential", 32'(conc_err), 32'd0);
    chk("wready_before_b", 32'(early_err), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
